// File: rtl/test_status_regs.sv
// Memory-mapped test status registers: progress/fail/pass codes, cycle counter, optional
// progress watchdog compiled in with TEST_STATUS_WDOG_EN.
module test_status_regs #(
  parameter int unsigned ADDR_W         = 3,
  parameter logic [31:0] ID_VALUE       = 32'h7E57_0001,
  parameter logic [31:0] WDOG_DEFAULT   = 32'd100000,
  parameter logic [31:0] WDOG_FAIL_CODE = 32'hDEAD_0001
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              bus_cs_i,
  input  logic              bus_we_i,
  input  logic [ADDR_W-1:0] bus_addr_i,
  input  logic [31:0]       bus_wdata_i,
  input  logic [3:0]        bus_wmask_i,
  output logic [31:0]       bus_rdata_o,
  output logic              bus_ack_o,
  output logic [31:0]       test_progress_o,
  output logic [31:0]       test_fail_o,
  output logic [31:0]       test_pass_o,
  output logic              test_done_o
);

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  logic [31:0] progress_q, progress_d, fail_q, fail_d, pass_q, pass_d;
  logic [31:0] scratch_q, scratch_d, cycles_q, cycles_d, rdata_q, rdata_d, rd_val;
  logic [31:0] wdog_limit_rd, wdog_count_rd;
  logic        ack_q, hit, wr_en, wr_prog, wr_fail, wr_pass, wr_scratch, wdog_expire;
  logic [2:0]  idx;

  assign idx = bus_addr_i[2:0];

  if (ADDR_W > 3) begin : g_wide
    assign hit = (bus_addr_i[ADDR_W-1:3] == '0);
  end else begin : g_narrow
    assign hit = 1'b1;
  end

  assign wr_en      = bus_cs_i & bus_we_i & hit;
  assign wr_prog    = wr_en & (idx == 3'd0);
  assign wr_fail    = wr_en & (idx == 3'd1);
  assign wr_pass    = wr_en & (idx == 3'd2);
  assign wr_scratch = wr_en & (idx == 3'd3);

  assign test_done_o = (fail_q != '0) | (pass_q != '0);

`ifdef TEST_STATUS_WDOG_EN
  logic [31:0] wdog_limit_q, wdog_limit_d, wdog_count_q, wdog_count_d;
  logic        wr_limit, wdog_clr, wdog_at_limit;

  assign wr_limit      = wr_en & (idx == 3'd5);
  assign wdog_clr      = wr_prog | wr_limit;
  assign wdog_at_limit = (wdog_limit_q != '0) && !test_done_o &&
                         (wdog_count_q == wdog_limit_q - 32'd1);
  assign wdog_expire   = wdog_at_limit & ~wdog_clr;

  always_comb begin
    wdog_limit_d = wr_limit ? merge(wdog_limit_q, bus_wdata_i, bus_wmask_i) : wdog_limit_q;
    wdog_count_d = wdog_count_q;
    if (wdog_clr) begin
      wdog_count_d = '0;
    end else if ((wdog_limit_q != '0) && !test_done_o && !wdog_at_limit) begin
      wdog_count_d = wdog_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_limit_q <= WDOG_DEFAULT;
      wdog_count_q <= '0;
    end else begin
      wdog_limit_q <= wdog_limit_d;
      wdog_count_q <= wdog_count_d;
    end
  end

  assign wdog_limit_rd = wdog_limit_q;
  assign wdog_count_rd = wdog_count_q;
`else
  logic unused_wdog_default;
  assign unused_wdog_default = ^WDOG_DEFAULT;
  assign wdog_expire   = 1'b0;
  assign wdog_limit_rd = '0;
  assign wdog_count_rd = '0;
`endif

  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (idx)
        3'd0:    rd_val = progress_q;
        3'd1:    rd_val = fail_q;
        3'd2:    rd_val = pass_q;
        3'd3:    rd_val = scratch_q;
        3'd4:    rd_val = cycles_q;
        3'd5:    rd_val = wdog_limit_rd;
        3'd6:    rd_val = wdog_count_rd;
        default: rd_val = ID_VALUE;
      endcase
    end
  end

  always_comb begin
    progress_d = wr_prog ? merge(progress_q, bus_wdata_i, bus_wmask_i) : progress_q;
    scratch_d  = wr_scratch ? merge(scratch_q, bus_wdata_i, bus_wmask_i) : scratch_q;
    cycles_d   = test_done_o ? cycles_q : cycles_q + 32'd1;
    rdata_d    = (bus_cs_i && !bus_we_i) ? rd_val : rdata_q;
    fail_d     = fail_q;
    pass_d     = pass_q;
    if (!test_done_o) begin
      if (wr_fail) fail_d = merge(fail_q, bus_wdata_i, bus_wmask_i);
      if (wr_pass) pass_d = merge(pass_q, bus_wdata_i, bus_wmask_i);
    end
    // A nonzero code written by the bus in the expiry cycle takes precedence
    if (wdog_expire && (fail_d == '0) && (pass_d == '0)) fail_d = WDOG_FAIL_CODE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      progress_q <= '0;
      fail_q     <= '0;
      pass_q     <= '0;
      scratch_q  <= '0;
      cycles_q   <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
    end else begin
      progress_q <= progress_d;
      fail_q     <= fail_d;
      pass_q     <= pass_d;
      scratch_q  <= scratch_d;
      cycles_q   <= cycles_d;
      rdata_q    <= rdata_d;
      ack_q      <= bus_cs_i;
    end
  end

  assign bus_rdata_o     = rdata_q;
  assign bus_ack_o       = ack_q;
  assign test_progress_o = progress_q;
  assign test_fail_o     = fail_q;
  assign test_pass_o     = pass_q;

endmodule

// File: tb/tb_test_status_regs.sv
// Scoreboard bench for test_status_regs: stimulus pushes expected acks/read data, a negedge
// monitor pops and compares.
module tb_test_status_regs;

  logic        clk, rst_n, cs, we, ack, done;
  logic [2:0]  addr;
  logic [31:0] wdata, rdata, progress, fail, pass;
  logic [3:0]  wmask;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int unsigned edges;
  int unsigned last_edge;
  logic [31:0] frozen;

`ifdef TEST_STATUS_WDOG_EN
  localparam logic [31:0] LimitAfterReset = 32'd100000;
`else
  localparam logic [31:0] LimitAfterReset = 32'd0;
`endif

  test_status_regs dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .bus_cs_i       (cs),
    .bus_we_i       (we),
    .bus_addr_i     (addr),
    .bus_wdata_i    (wdata),
    .bus_wmask_i    (wmask),
    .bus_rdata_o    (rdata),
    .bus_ack_o      (ack),
    .test_progress_o(progress),
    .test_fail_o    (fail),
    .test_pass_o    (pass),
    .test_done_o    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges seen since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  always @(negedge clk) begin
    if (ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack with no request outstanding (rdata=%h)", rdata);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_read) begin
          checks++;
          if (rdata !== mon_e.data) begin
            errors++;
            $display("FAIL %s: rdata=%h expected=%h", mon_e.name, rdata, mon_e.data);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic bus_req(input logic w, input logic [2:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic [31:0] exp, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    last_edge = edges;
    cs = 1'b1; we = w; addr = a; wdata = d; wmask = m;
    e.is_read = !w;
    e.data    = exp;
    e.name    = name;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cs = 1'b0; we = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; wdata = '0; wmask = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_ack_done", {30'd0, ack, done}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_progress", progress, 32'd0);

    // ID then CYCLES back-to-back; CYCLES sampled after two post-release edges
    bus_req(1'b0, 3'd7, '0, '0, 32'h7E57_0001, "read_id");
    bus_req(1'b0, 3'd4, '0, '0, 32'd2, "read_cycles_since_release");
    idle(1);

    // Byte-masked PROGRESS writes
    bus_req(1'b1, 3'd0, 32'h0000_0005, 4'b0001, '0, "wr_prog0");
    bus_req(1'b1, 3'd0, 32'h1234_5678, 4'b1100, '0, "wr_prog1");
    check("progress_after_first_write", progress, 32'h0000_0005);
    idle(1);
    check("progress_after_second_write", progress, 32'h1234_0005);
    bus_req(1'b0, 3'd0, '0, '0, 32'h1234_0005, "read_progress");
    bus_req(1'b1, 3'd3, 32'hA5A5_5A5A, 4'b1111, '0, "wr_scratch0");
    bus_req(1'b1, 3'd3, 32'hFFFF_FFFF, 4'b0010, '0, "wr_scratch1");
    bus_req(1'b0, 3'd3, '0, '0, 32'hA5A5_FF5A, "read_scratch");
    bus_req(1'b1, 3'd7, 32'h0, 4'b1111, '0, "wr_id_ignored");
    bus_req(1'b0, 3'd7, '0, '0, 32'h7E57_0001, "read_id_after_write");
    idle(1);
    check("done_before_pass", {31'd0, done}, 32'd0);

    // PASS then FAIL: FAIL write must be dropped, CYCLES freezes
    bus_req(1'b1, 3'd2, 32'h0000_0001, 4'b1111, '0, "wr_pass");
    frozen = 32'(last_edge + 1);
    bus_req(1'b1, 3'd1, 32'h0000_00FF, 4'b1111, '0, "wr_fail_after_pass");
    idle(1);
    check("done_after_pass", {31'd0, done}, 32'd1);
    check("pass_value", pass, 32'd1);
    check("fail_sticky_zero", fail, 32'd0);
    bus_req(1'b0, 3'd1, '0, '0, 32'd0, "read_fail");
    bus_req(1'b0, 3'd2, '0, '0, 32'd1, "read_pass");
    bus_req(1'b0, 3'd4, '0, '0, frozen, "read_cycles_frozen0");
    idle(5);
    bus_req(1'b0, 3'd4, '0, '0, frozen, "read_cycles_frozen1");
    idle(2);

    // Reset asserted during a read request: no ack, everything cleared
    @(posedge clk);
    #1;
    cs = 1'b1; we = 1'b0; addr = 3'd2;
    #2;
    rst_n = 1'b0;
    cs = 1'b0;
    @(negedge clk);
    check("rst_mid_ack", {31'd0, ack}, 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    check("rst_mid_progress", progress, 32'd0);
    check("rst_mid_fail_pass", fail | pass, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_req(1'b0, 3'd5, '0, '0, LimitAfterReset, "read_wdog_limit_after_reset");
    idle(2);

`ifdef TEST_STATUS_WDOG_EN
    // Plain expiry: limit written at T, FAIL appears after edge T+11
    do_reset();
    bus_req(1'b1, 3'd5, 32'd10, 4'b1111, '0, "wr_limit10");
    idle(10);
    check("wdog_no_fail_in_expiry_cycle", fail, 32'd0);
    idle(1);
    check("wdog_fail_code", fail, 32'hDEAD_0001);
    bus_req(1'b0, 3'd6, '0, '0, 32'd9, "wdog_count_held");
    bus_req(1'b0, 3'd5, '0, '0, 32'd10, "wdog_limit_read");
    idle(1);

    // Zero-mask PROGRESS write in the expiry cycle clears the count
    do_reset();
    bus_req(1'b1, 3'd5, 32'd10, 4'b1111, '0, "wr_limit10b");
    idle(9);
    bus_req(1'b1, 3'd0, 32'h0, 4'b0000, '0, "wr_prog_expiry");
    bus_req(1'b0, 3'd6, '0, '0, 32'd0, "wdog_count_restart");
    check("wdog_clear_no_fail", fail, 32'd0);
    idle(1);

    // FAIL write in the expiry cycle wins
    do_reset();
    bus_req(1'b1, 3'd5, 32'd10, 4'b1111, '0, "wr_limit10c");
    idle(9);
    bus_req(1'b1, 3'd1, 32'h0000_0042, 4'b1111, '0, "wr_fail_expiry");
    idle(1);
    check("wdog_bus_fail_wins", fail, 32'h0000_0042);

    // Limit set to 0 stops the watchdog
    do_reset();
    bus_req(1'b1, 3'd5, 32'd3, 4'b1111, '0, "wr_limit3");
    idle(1);
    bus_req(1'b1, 3'd5, 32'd0, 4'b1111, '0, "wr_limit0");
    idle(10);
    check("wdog_disabled_no_fail", fail, 32'd0);
    bus_req(1'b0, 3'd6, '0, '0, 32'd0, "wdog_disabled_count");
    idle(2);
`endif

    idle(3);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
